// File: rtl/soc_rst_seq.sv
// ---------------------------------------------------------------------------
// soc_rst_seq
//   Reset sequencer for soc_top. Stretches the incoming reset, then releases
//   the memory, core and peripheral resets in that order with a fixed gap
//   between stages. A software request or, optionally, a watchdog timeout
//   re-enters the sequence. The cause of the last reset is reported.
//
// Optional feature macro: RST_WDT_EN (watchdog timeout reset)
//
// Parameters
//   STRETCH_CYCLES : cycles all resets stay asserted after rst falls (>=1)
//   STAGE_GAP      : cycles between successive stage releases (>=1)
//   WDT_TIMEOUT    : watchdog period in cycles (>=2), RST_WDT_EN only
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   sw_rst_req   in   software reset request, sampled every cycle
//   wdt_kick     in   watchdog refresh (ignored without RST_WDT_EN)
//   mem_rst_o    out  memory-subsystem reset, active-high
//   core_rst_o   out  core reset, active-high
//   periph_rst_o out  peripheral reset, active-high
//   rst_done_o   out  high once every stage has been released
//   rst_cause_o  out  last cause: 00 external, 01 software, 10 watchdog
// ---------------------------------------------------------------------------
module soc_rst_seq #(
  parameter int STRETCH_CYCLES = 16,
  parameter int STAGE_GAP      = 4,
  parameter int WDT_TIMEOUT    = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw_rst_req,
  input  logic       wdt_kick,
  output logic       mem_rst_o,
  output logic       core_rst_o,
  output logic       periph_rst_o,
  output logic       rst_done_o,
  output logic [1:0] rst_cause_o
);

  typedef enum logic [1:0] {
    HOLD        = 2'd0,
    WAIT_CORE   = 2'd1,
    WAIT_PERIPH = 2'd2,
    RUN         = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_EXT = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;

  // One shared stage counter, sized so the larger of the two limits fits
  // without wrapping.
  localparam int CNT_MAX = (STRETCH_CYCLES > STAGE_GAP) ? STRETCH_CYCLES : STAGE_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] STRETCH_LAST = CW'(STRETCH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP - 1);

  state_t        r_state;
  logic [CW-1:0] r_cnt;
  logic          r_memRst;
  logic          r_coreRst;
  logic          r_periphRst;
  logic          r_done;
  logic [1:0]    r_cause;

  // Software requests only count once the sequence has left HOLD; inside
  // HOLD they neither restart nor extend the stretch.
  logic w_swEvent;
  assign w_swEvent = sw_rst_req && (r_state != HOLD);

`ifdef RST_WDT_EN
  localparam logic [1:0] CAUSE_WDT = 2'b10;
  localparam int WW = $clog2(WDT_TIMEOUT);
  localparam logic [WW-1:0] WDT_LAST = WW'(WDT_TIMEOUT - 1);

  logic [WW-1:0] r_wdtCnt;
  logic          w_wdtEvent;

  // A kick in the timeout cycle suppresses the reset.
  assign w_wdtEvent = (r_state == RUN) && !wdt_kick && (r_wdtCnt == WDT_LAST);

  // Watchdog counter only advances in RUN; any other state, a kick or a
  // firing holds it at zero so each RUN entry starts a fresh period.
  always_ff @(posedge clk) begin
    if (rst || (r_state != RUN) || wdt_kick || w_wdtEvent) begin
      r_wdtCnt <= '0;
    end else begin
      r_wdtCnt <= r_wdtCnt + 1'b1;
    end
  end
`else
  logic w_unusedWdt;
  assign w_unusedWdt = wdt_kick | (WDT_TIMEOUT < 2);
`endif

  // Sequencer FSM with registered outputs. Reset events are checked in
  // priority order rst > software > watchdog before normal progression.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= HOLD;
      r_cnt       <= '0;
      r_memRst    <= 1'b1;
      r_coreRst   <= 1'b1;
      r_periphRst <= 1'b1;
      r_done      <= 1'b0;
      r_cause     <= CAUSE_EXT;
    end else if (w_swEvent) begin
      r_state     <= HOLD;
      r_cnt       <= '0;
      r_memRst    <= 1'b1;
      r_coreRst   <= 1'b1;
      r_periphRst <= 1'b1;
      r_done      <= 1'b0;
      r_cause     <= CAUSE_SW;
    end
`ifdef RST_WDT_EN
    else if (w_wdtEvent) begin
      r_state     <= HOLD;
      r_cnt       <= '0;
      r_memRst    <= 1'b1;
      r_coreRst   <= 1'b1;
      r_periphRst <= 1'b1;
      r_done      <= 1'b0;
      r_cause     <= CAUSE_WDT;
    end
`endif
    else begin
      case (r_state)
        HOLD: begin
          if (r_cnt == STRETCH_LAST) begin
            r_state  <= WAIT_CORE;
            r_cnt    <= '0;
            r_memRst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_CORE: begin
          if (r_cnt == GAP_LAST) begin
            r_state   <= WAIT_PERIPH;
            r_cnt     <= '0;
            r_coreRst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        WAIT_PERIPH: begin
          if (r_cnt == GAP_LAST) begin
            r_state     <= RUN;
            r_cnt       <= '0;
            r_periphRst <= 1'b0;
            r_done      <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RUN: begin
          r_cnt <= '0;
        end
        default: begin
          r_state     <= HOLD;
          r_cnt       <= '0;
          r_memRst    <= 1'b1;
          r_coreRst   <= 1'b1;
          r_periphRst <= 1'b1;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rst_o    = r_memRst;
  assign core_rst_o   = r_coreRst;
  assign periph_rst_o = r_periphRst;
  assign rst_done_o   = r_done;
  assign rst_cause_o  = r_cause;

endmodule

// File: tb/tb_soc_rst_seq.sv
// ---------------------------------------------------------------------------
// tb_soc_rst_seq
//   Self-checking bench for soc_rst_seq. A timeline model predicts every
//   output from the edge at which the current release sequence started;
//   directed vectors add hand-computed literal checks on top of it.
//   Define RST_WDT_EN in both RTL and bench to exercise the watchdog.
// ---------------------------------------------------------------------------
module tb_soc_rst_seq;

  localparam int S = 16;
  localparam int G = 4;
  localparam int T = 8;

  logic       clk;
  logic       rst;
  logic       swRstReq;
  logic       wdtKick;
  logic       memRst;
  logic       coreRst;
  logic       periphRst;
  logic       rstDone;
  logic [1:0] rstCause;

  int total = 0;
  int bad   = 0;

  soc_rst_seq #(
    .STRETCH_CYCLES(S),
    .STAGE_GAP     (G),
    .WDT_TIMEOUT   (T)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw_rst_req  (swRstReq),
    .wdt_kick    (wdtKick),
    .mem_rst_o   (memRst),
    .core_rst_o  (coreRst),
    .periph_rst_o(periphRst),
    .rst_done_o  (rstDone),
    .rst_cause_o (rstCause)
  );

  // Free-running 10 time-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0b required %0b at %0t", name, act, exp, $time);
    end
  endtask

  // Drive inputs at the current falling edge and let the given number of
  // cycles pass, ending on a falling edge again.
  task automatic applyStimulus(input logic r, input logic sw, input logic kick, input int cycles);
    rst      = r;
    swRstReq = sw;
    wdtKick  = kick;
    repeat (cycles) @(negedge clk);
  endtask

  // Timeline model: the sequence is described only by the edge index at
  // which stretch counting begins (seqStart). Every output after edge n is
  // a comparison of n against fixed offsets from that edge.
  int         edgeN     = 0;
  int         seqStart  = 0;
  int         lastKick  = -1;
  logic [1:0] modelCause = 2'b00;

  always @(posedge clk) begin
    int  runEdge;
    int  clrEdge;
    bit  inHold;
    bit  inRun;
    edgeN   = edgeN + 1;
    runEdge = seqStart + S + 2 * G - 1;
    inHold  = (edgeN - 1) < (seqStart + S - 1);
    inRun   = (edgeN - 1) >= runEdge;
    clrEdge = (lastKick > runEdge) ? lastKick : runEdge;
    if (rst) begin
      seqStart   = edgeN + 1;
      modelCause = 2'b00;
    end else if (swRstReq && !inHold) begin
      seqStart   = edgeN + 1;
      modelCause = 2'b01;
    end
`ifdef RST_WDT_EN
    else if (inRun && !wdtKick && (edgeN - clrEdge == T)) begin
      seqStart   = edgeN + 1;
      modelCause = 2'b10;
    end
`endif
    if (wdtKick) lastKick = edgeN;
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (edgeN >= 1) begin
      checkOutput("model_mem",    {1'b0, memRst},    {1'b0, edgeN < seqStart + S - 1});
      checkOutput("model_core",   {1'b0, coreRst},   {1'b0, edgeN < seqStart + S + G - 1});
      checkOutput("model_periph", {1'b0, periphRst}, {1'b0, edgeN < seqStart + S + 2 * G - 1});
      checkOutput("model_done",   {1'b0, rstDone},   {1'b0, edgeN >= seqStart + S + 2 * G - 1});
      checkOutput("model_cause",  rstCause,          modelCause);
    end
  end

  // Literal walk through one release. Entered on a falling edge whose next
  // rising edge is the first counting edge E0. Optionally pulses the
  // software request while still in HOLD, which must not move the timing.
  task automatic checkReleaseSeq(input logic [1:0] expCause, input bit swInHold);
    if (swInHold) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 5);
      applyStimulus(1'b0, 1'b1, 1'b0, 1);
      applyStimulus(1'b0, 1'b0, 1'b0, 9);
    end else begin
      applyStimulus(1'b0, 1'b0, 1'b0, 15);
    end
    checkOutput("mem_held_E14",     {1'b0, memRst},    2'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("mem_release_E15",  {1'b0, memRst},    2'd0);
    checkOutput("core_held_E15",    {1'b0, coreRst},   2'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3);
    checkOutput("core_held_E18",    {1'b0, coreRst},   2'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("core_release_E19", {1'b0, coreRst},   2'd0);
    checkOutput("periph_held_E19",  {1'b0, periphRst}, 2'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3);
    checkOutput("done_low_E22",     {1'b0, rstDone},   2'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkOutput("periph_release_E23", {1'b0, periphRst}, 2'd0);
    checkOutput("done_high_E23",      {1'b0, rstDone},   2'd1);
    checkOutput("cause_after_done",   rstCause,          expCause);
  endtask

  task automatic checkAllAsserted(input string tag, input logic [1:0] expCause);
    checkOutput({tag, "_mem"},    {1'b0, memRst},    2'd1);
    checkOutput({tag, "_core"},   {1'b0, coreRst},   2'd1);
    checkOutput({tag, "_periph"}, {1'b0, periphRst}, 2'd1);
    checkOutput({tag, "_done"},   {1'b0, rstDone},   2'd0);
    checkOutput({tag, "_cause"},  rstCause,          expCause);
  endtask

  initial begin
    rst      = 1'b1;
    swRstReq = 1'b0;
    wdtKick  = 1'b0;

    // Power-on reset for two cycles, then the default release.
    applyStimulus(1'b1, 1'b0, 1'b0, 2);
    checkAllAsserted("reset_state", 2'b00);
    checkReleaseSeq(2'b00, 1'b0);

    // One-cycle software pulse in RUN.
    applyStimulus(1'b0, 1'b0, 1'b0, 5);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkAllAsserted("sw_pulse", 2'b01);
    checkReleaseSeq(2'b01, 1'b0);

    // rst glitch while waiting to release the core.
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    applyStimulus(1'b0, 1'b0, 1'b0, 17);
    checkOutput("wait_core_mem",  {1'b0, memRst},  2'd0);
    checkOutput("wait_core_core", {1'b0, coreRst}, 2'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    checkAllAsserted("rst_glitch", 2'b00);
    checkReleaseSeq(2'b00, 1'b1);

    // rst and software request together in RUN: external cause wins.
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkReleaseSeq(2'b01, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1);
    checkAllAsserted("rst_and_sw", 2'b00);
    checkReleaseSeq(2'b00, 1'b0);

`ifdef RST_WDT_EN
    // No kick: reset T cycles after entering RUN.
    applyStimulus(1'b0, 1'b0, 1'b0, 7);
    checkOutput("wdt_before_timeout", {1'b0, rstDone}, 2'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1);
    checkAllAsserted("wdt_fire", 2'b10);
    checkReleaseSeq(2'b10, 1'b0);

    // Kick in the timeout cycle wins; the next timeout collides with a
    // software request, which takes the cause.
    applyStimulus(1'b0, 1'b0, 1'b0, 7);
    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    checkOutput("wdt_kick_in_timeout", {1'b0, rstDone}, 2'd1);
    applyStimulus(1'b0, 1'b0, 1'b0, 7);
    checkOutput("wdt_after_late_kick", {1'b0, rstDone}, 2'd1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    checkAllAsserted("wdt_and_sw", 2'b01);
    checkReleaseSeq(2'b01, 1'b0);

    // Kick every 5 cycles for 100 cycles: no reset.
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 4);
      applyStimulus(1'b0, 1'b0, 1'b1, 1);
      checkOutput("wdt_kicked_done", {1'b0, rstDone}, 2'd1);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 2);
`else
    // Without the watchdog, RUN persists with no kicks at all.
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 50);
      checkOutput("nowdt_done",  {1'b0, rstDone}, 2'd1);
      checkOutput("nowdt_cause", rstCause,        2'b00);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/soc_rst_seq.md
# soc_rst_seq

Reset sequencer that sits inside `soc_top`, directly behind the top-level `clk`/`rst` pins driven by the SoC bench or board. It stretches the incoming reset and releases memory, core and peripheral resets in a fixed order with programmable gaps. It also accepts a software reset request and optionally a watchdog timeout. It reports when the SoC is out of reset and which event caused the last reset.

## Interface
- `STRETCH_CYCLES`, 16: cycles all resets stay asserted after `rst` falls; ≥1.
- `STAGE_GAP`, 4: cycles between successive stage releases; ≥1.
- `WDT_TIMEOUT`, 1024: watchdog period in cycles; ≥2; used only with `RST_WDT_EN`.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `sw_rst_req`  in  1  software reset request from CSR, level or pulse, sampled each cycle.
- `wdt_kick`  in  1  watchdog refresh; port always present.
- `mem_rst_o`  out  1  memory-subsystem reset, active-high.
- `core_rst_o`  out  1  core reset, active-high.
- `periph_rst_o`  out  1  peripheral reset, active-high.
- `rst_done_o`  out  1  high when every stage is released.
- `rst_cause_o`  out  2  last reset cause: 00 external, 01 software, 10 watchdog.

## Operation
- States:
  - HOLD: all resets asserted; stretch counter running.
  - WAIT_CORE: memory released; gap counter running.
  - WAIT_PERIPH: core released; gap counter running.
  - RUN: all released; `rst_done_o`=1.
- Transitions:
  - HOLD → WAIT_CORE when the counter reaches STRETCH_CYCLES−1.
  - WAIT_CORE → WAIT_PERIPH when the counter reaches STAGE_GAP−1.
  - WAIT_PERIPH → RUN when the counter reaches STAGE_GAP−1.
  - The counter clears on every state change.
- `rst`=1 in any state: next state is HOLD, counter 0, every reset output 1, `rst_done_o`=0, `rst_cause_o`=00.
- `sw_rst_req`=1 in WAIT_CORE, WAIT_PERIPH or RUN: next state is HOLD, every reset re-asserted, cause=01.
- `sw_rst_req` is ignored in HOLD; the counter is not restarted.
- Event priority: `rst` > `sw_rst_req` > watchdog.
- `rst_cause_o` changes only on a reset event and holds through release and RUN.
- All outputs are registered; there is no combinational path from input to output.

## Timing
- Reset values:
  - `mem_rst_o`=`core_rst_o`=`periph_rst_o`=1
  - `rst_done_o`=0
  - `rst_cause_o`=00
  - state HOLD
- Release timing, with E0 = first rising edge at which `rst` is sampled 0:
  - `mem_rst_o` falls after edge E0+STRETCH_CYCLES−1.
  - `core_rst_o` falls after E0+STRETCH_CYCLES+STAGE_GAP−1.
  - `periph_rst_o` and `rst_done_o` change after E0+STRETCH_CYCLES+2·STAGE_GAP−1.
- Re-assertion: a request sampled at edge Ek asserts every reset and clears `rst_done_o` after Ek. The release then repeats relative to Ek+1.
- `rst` glitch mid-sequence, even for one cycle: the full sequence restarts from HOLD.
- Counters are wide enough for the largest parameter; a counter never wraps.

## Configuration
- `RST_WDT_EN` defined: watchdog counter runs only in RUN and clears on entering RUN or on `wdt_kick`=1.
  - Reaching WDT_TIMEOUT−1 without a kick gives HOLD next cycle, cause=10.
  - A kick in the timeout cycle wins: no reset.
  - `sw_rst_req` in the same cycle gives cause=01.
- `RST_WDT_EN` undefined: no watchdog logic; `wdt_kick` is ignored; `rst_cause_o` never reads 10.

## Test plan
- Defaults, `rst`=1 for 2 cycles then 0:
  - mem release 16 cycles after E0; core 4 cycles later; periph and done 4 cycles after core.
  - Cause=00.
- `sw_rst_req` one-cycle pulse in RUN: all resets 1 the next cycle and done=0. Full 16/4/4 re-release follows, cause=01 held after done.
- `rst` pulse of 1 cycle during WAIT_CORE: core stays in reset, mem re-asserts, sequence restarts, cause=00.
- `rst` and `sw_rst_req` high in the same cycle in RUN: cause=00.
- With `RST_WDT_EN`, WDT_TIMEOUT=8, no kick:
  - Reset 8 cycles after entering RUN, cause=10.
  - Repeating with a kick every 5 cycles gives no reset over 100 cycles.
- Without `RST_WDT_EN`: no kicks for 5000 cycles in RUN; `rst_done_o` stays 1 and cause stays 00.
